main_memory_responder: RTL
==========================

Name: main_memory_responder

Overview:
- Responder (memory side) of the single-word main-memory request/ready interface driven by the L1 cache arbiter.
- Accepts one read or write per request from the initiator.
- Services it from an internal word array after a programmable wait-state count.
- Returns a one-cycle ready pulse with read data. Used as the backing store in core-level simulation and as the FPGA on-chip RAM model.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; the word size is DATA_WIDTH/8 bytes
DEPTH_WORDS, 1024, number of words stored; must be a power of two
BASE_ADDR, 32'h0000_0000, byte address of word 0
READ_LATENCY, 2, cycles from request sample to ready on reads; values below 1 are treated as 1
WRITE_LATENCY, 1, cycles from request sample to ready on writes; values below 1 are treated as 1

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
mem_req  input  1  request valid from the initiator
mem_we  input  1  1 = write, 0 = read
mem_addr  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits are ignored
mem_wdata  input  DATA_WIDTH  write data
mem_rdata  output  DATA_WIDTH  read data; valid while mem_ready=1
mem_ready  output  1  one-cycle completion pulse
busy  output  1  high in WAIT and RESP states

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, mem_ready=0, mem_rdata=0, busy=0, wait counter=0.
  - Array contents are not reset.
- States: IDLE, WAIT, RESP.
- IDLE:
  - At a rising edge with mem_req=1, capture mem_we, mem_addr and mem_wdata.
  - Load counter = latency-1 (READ_LATENCY or WRITE_LATENCY, selected by the captured we).
  - If counter=0, go to RESP; else go to WAIT.
- WAIT:
  - Decrement the counter each edge; go to RESP on the edge where it reaches 0.
  - Input changes during WAIT are ignored; the captured values are used.
- RESP: mem_ready=1 for exactly this cycle. Unconditional return to IDLE at the next edge.
- Latency: the request is sampled at edge E0; mem_ready is high in the cycle after edge E(L-1), i.e. L cycles after the sample.
- Read:
  - Read data is registered on entry to RESP.
  - mem_rdata holds that value after RESP until the next read response. Writes do not disturb it.
- Write:
  - The array word is updated at the edge entering RESP.
  - A reset asserted before that edge drops the write.
- Index = ((captured_addr - BASE_ADDR) >> log2(DATA_WIDTH/8)) mod DEPTH_WORDS. The subtraction is modulo 2^ADDR_WIDTH; out-of-range addresses alias (wrap).
- Back-to-back: a request is sampled only in IDLE, so the minimum issue interval is L+1 cycles. The initiator must drop or change mem_req in the cycle after mem_ready. A mem_req still high in IDLE is a new request.
- mem_req low in IDLE: outputs hold; no array access.
- Reset mid-operation: immediate return to IDLE, mem_ready=0; the pending transaction is discarded.

Optional Feature:
- MEM_BOUNDS_CHECK_EN defined:
  - Adds output mem_err (1 bit, reset 0).
  - A captured address is out of range if it is below BASE_ADDR or at/above BASE_ADDR + DEPTH_WORDS*(DATA_WIDTH/8).
  - On an out-of-range request, latency is unchanged; mem_err=1 coincident with mem_ready for that cycle only.
  - Out-of-range reads return 0; out-of-range writes leave the array unchanged.
- MEM_BOUNDS_CHECK_EN undefined: no mem_err port; addresses wrap as above.

Test Plan:
- Write then read, defaults:
  - Write addr 0x10, data 0xDEADBEEF -> mem_ready 1 cycle after the sample.
  - Read 0x10 -> mem_ready 2 cycles after the sample, mem_rdata=0xDEADBEEF.
- Latency sweep: READ_LATENCY=1,3,5 -> mem_ready exactly L cycles after the sampling edge, high exactly 1 cycle, busy high from the sample+1 cycle through RESP.
- Inputs change during WAIT: read 0x20 (holds 0x1111_1111); at WAIT cycle 1 set addr=0x24, we=1 -> response returns 0x1111_1111; word 0x24 is unchanged.
- Back-to-back with mem_req held high for 6 cycles, READ_LATENCY=2 -> two responses, 3 cycles apart.
- Wrap: DEPTH_WORDS=1024, write 0x1000 with 0xA5A5A5A5 -> read 0x0 returns 0xA5A5A5A5. With MEM_BOUNDS_CHECK_EN: mem_err=1 on the write, read 0x0 returns its prior value, read 0x1000 returns 0 with mem_err=1.
- Reset mid-write: write 0x8 with 0x55, WRITE_LATENCY=3; assert rst_n low in the WAIT cycle -> mem_ready stays 0; a read of 0x8 after reset returns the old value.

Source files
------------

// File: rtl/main_memory_responder.sv
// Single-word main-memory responder with programmable read/write wait states.
// Optional MEM_BOUNDS_CHECK_EN adds mem_err and out-of-range suppression.
module main_memory_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_ready,
`ifdef MEM_BOUNDS_CHECK_EN
  output logic                  mem_err,
`endif
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int IDXW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int RL    = (READ_LATENCY < 1) ? 1 : READ_LATENCY;
  localparam int WL    = (WRITE_LATENCY < 1) ? 1 : WRITE_LATENCY;
  localparam int CW    = 16;
  localparam logic [CW-1:0] RL_M1 = CW'(RL - 1);
  localparam logic [CW-1:0] WL_M1 = CW'(WL - 1);
`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] SPAN =
    (ADDR_WIDTH+1)'(DEPTH_WORDS * BYTES);
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_idle;
  logic [CW-1:0]         w_ld;
  logic                  w_fire;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDXW-1:0]       w_idx;
  logic                  w_inb;
  logic                  w_wr;
  logic                  w_unused;

  // In IDLE the live inputs are used so a latency-1 access
  // completes on the sampling edge itself.
  assign w_idle  = (r_state == IDLE);
  assign w_ld    = mem_we ? WL_M1 : RL_M1;
  assign w_fire  = (w_idle && mem_req && (w_ld == '0)) ||
                   ((r_state == WAIT) && (r_cnt == CW'(1)));
  assign w_we    = w_idle ? mem_we    : r_we;
  assign w_addr  = w_idle ? mem_addr  : r_addr;
  assign w_wdata = w_idle ? mem_wdata : r_wdata;
  assign w_off   = w_addr - BASE_ADDR;
  assign w_word  = w_off >> OFF;
  assign w_idx   = w_word[IDXW-1:0];
`ifdef MEM_BOUNDS_CHECK_EN
  assign w_inb   = ({1'b0, w_off} < SPAN);
`else
  assign w_inb   = 1'b1;
`endif
  assign w_wr     = rst_n && w_fire && w_we && w_inb;
  assign w_unused = ^{w_off, w_word};

  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign busy      = r_busy;
`ifdef MEM_BOUNDS_CHECK_EN
  assign mem_err   = r_err;
`endif

  // Request FSM: capture, count wait states, pulse ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (mem_req) begin
            r_we    <= mem_we;
            r_addr  <= mem_addr;
            r_wdata <= mem_wdata;
            r_cnt   <= w_ld;
            r_busy  <= 1'b1;
            r_state <= (w_ld == '0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= RESP;
        end
        RESP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (w_fire) begin
        r_ready <= 1'b1;
        r_err   <= !w_inb;
        if (!w_we) r_rdata <= w_inb ? r_mem[w_idx] : '0;
      end
    end
  end

  // Word array, not reset; written on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_idx] <= w_wdata;
  end

endmodule
